// File: rtl/fifo.sv
// Single-clock first-word-fall-through FIFO with enqueue/dequeue handshakes.
// The head word is driven combinationally from storage at the read pointer.
module fifo #(
  parameter int p_WORD_LEN  = 8,
  parameter int p_FIFO_SIZE = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  output logic                  o_full,
  output logic                  o_empty,
  input  logic [p_WORD_LEN-1:0] enq_data,
  input  logic                  enq_en,
  output logic                  enq_rdy,
  output logic [p_WORD_LEN-1:0] deq_data,
  input  logic                  deq_en,
  output logic                  deq_rdy
);

  localparam int PW = $clog2(p_FIFO_SIZE);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(p_FIFO_SIZE);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [p_WORD_LEN-1:0] mem_q [p_FIFO_SIZE];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW:0]           count_q, count_d;
  logic                  do_enq, do_deq;

  // Handshake: a transfer happens on a rising edge exactly when the request
  // (enq_en / deq_en) and the matching ready are both high in that cycle.
  // Ready depends only on stored count, never on the requests, so a full FIFO
  // rejects a same-cycle enqueue even while a dequeue frees a slot.
  assign o_full   = (count_q == FULL_CNT);
  assign o_empty  = (count_q == '0);
  assign enq_rdy  = ~o_full;
  assign deq_rdy  = ~o_empty;
  assign deq_data = mem_q[rd_ptr_q];

  assign do_enq = enq_en && enq_rdy;
  assign do_deq = deq_en && deq_rdy;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_enq) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_deq) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_enq, do_deq})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; contents are unobservable while empty.
  always_ff @(posedge i_clk) begin
    if (do_enq) mem_q[wr_ptr_q] <= enq_data;
  end

endmodule

// File: tb/tb_fifo.sv
// Bench for fifo: directed scenarios plus random traffic, checked against
// a queue-based model of the FIFO's documented behaviour.
module tb_fifo;

  localparam int W     = 8;
  localparam int DEPTH = 8;

  logic         clk;
  logic         rst_n;
  logic         o_full, o_empty, enq_rdy, deq_rdy;
  logic [W-1:0] enq_data, deq_data;
  logic         enq_en, deq_en;

  logic [W-1:0] exp_q[$];
  int           n_pass;
  int           n_total;

  fifo #(.p_WORD_LEN(W), .p_FIFO_SIZE(DEPTH)) dut (
    .i_clk    (clk),
    .i_rstn   (rst_n),
    .o_full   (o_full),
    .o_empty  (o_empty),
    .enq_data (enq_data),
    .enq_en   (enq_en),
    .enq_rdy  (enq_rdy),
    .deq_data (deq_data),
    .deq_en   (deq_en),
    .deq_rdy  (deq_rdy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: one clock cycle of requests; the model decides acceptance from
  // its own occupancy before the edge.
  task automatic step(input logic en, input logic [W-1:0] d, input logic de);
    logic enq_ok, deq_ok;
    enq_en   = en;
    enq_data = d;
    deq_en   = de;
    enq_ok   = en && (exp_q.size() < DEPTH);
    deq_ok   = de && (exp_q.size() > 0);
    @(posedge clk);
    if (deq_ok) void'(exp_q.pop_front());
    if (enq_ok) exp_q.push_back(d);
    #1;
    enq_en = 1'b0;
    deq_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enq_en = 1'b0; deq_en = 1'b0; enq_data = '0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (o_empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", o_empty); else n_pass++;
    n_total++; if (o_full  !== 1'b0) $display("FAIL reset_full: got %b want 0", o_full); else n_pass++;
    n_total++; if (enq_rdy !== 1'b1) $display("FAIL reset_enq_rdy: got %b want 1", enq_rdy); else n_pass++;
    n_total++; if (deq_rdy !== 1'b0) $display("FAIL reset_deq_rdy: got %b want 0", deq_rdy); else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fill_overflow();
    logic [W-1:0] first;
    first = W'($urandom_range(0, 255));
    for (int i = 0; i < 10; i++) begin
      step(1'b1, (i == 0) ? first : W'($urandom_range(0, 255)), 1'b0);
      if (i == 0) begin
        n_total++; if (deq_data !== first || deq_rdy !== 1'b1)
          $display("FAIL fill_latency: got data %h rdy %b want %h 1", deq_data, deq_rdy, first); else n_pass++;
      end
      n_total++; if (o_full !== (i >= 7))
        $display("FAIL fill_full[%0d]: got %b want %b", i, o_full, (i >= 7)); else n_pass++;
    end
    n_total++; if (exp_q.size() != DEPTH || enq_rdy !== 1'b0)
      $display("FAIL fill_dropped: got enq_rdy %b want 0 (model size %0d)", enq_rdy, exp_q.size()); else n_pass++;
    n_total++; if (deq_data !== first)
      $display("FAIL fill_head_kept: got %h want %h", deq_data, first); else n_pass++;
  endtask

  task automatic test_drain_underflow();
    for (int i = 0; i < 10; i++) begin
      if (exp_q.size() > 0) begin
        n_total++; if (deq_data !== exp_q[0])
          $display("FAIL drain_data[%0d]: got %h want %h", i, deq_data, exp_q[0]); else n_pass++;
      end
      step(1'b0, '0, 1'b1);
      n_total++; if (o_empty !== (i >= 7) || deq_rdy !== (i < 7))
        $display("FAIL drain_empty[%0d]: got empty %b rdy %b want %b %b", i, o_empty, deq_rdy, (i >= 7), (i < 7)); else n_pass++;
    end
  endtask

  task automatic test_simul_one();
    step(1'b1, 8'h11, 1'b0);
    n_total++; if (deq_data !== 8'h11)
      $display("FAIL simul_one_first: got %h want 11", deq_data); else n_pass++;
    step(1'b1, 8'h22, 1'b1);
    n_total++; if (deq_data !== 8'h22 || o_empty !== 1'b0 || o_full !== 1'b0)
      $display("FAIL simul_one_swap: got data %h empty %b full %b want 22 0 0", deq_data, o_empty, o_full); else n_pass++;
    step(1'b0, '0, 1'b1);
    n_total++; if (o_empty !== 1'b1)
      $display("FAIL simul_one_count: got empty %b want 1", o_empty); else n_pass++;
    // dequeue and enqueue together while empty: only the enqueue lands
    step(1'b1, 8'h33, 1'b1);
    n_total++; if (o_empty !== 1'b0 || deq_data !== 8'h33)
      $display("FAIL simul_empty: got empty %b data %h want 0 33", o_empty, deq_data); else n_pass++;
    step(1'b0, '0, 1'b1);
    n_total++; if (o_empty !== 1'b1)
      $display("FAIL simul_empty_count: got empty %b want 1", o_empty); else n_pass++;
  endtask

  task automatic test_full_simul();
    int drained;
    for (int i = 0; i < DEPTH; i++) step(1'b1, W'($urandom_range(0, 255)), 1'b0);
    n_total++; if (o_full !== 1'b1)
      $display("FAIL full_simul_fill: got %b want 1", o_full); else n_pass++;
    step(1'b1, 8'hEE, 1'b1);
    n_total++; if (o_full !== 1'b0 || enq_rdy !== 1'b1)
      $display("FAIL full_simul_flags: got full %b enq_rdy %b want 0 1", o_full, enq_rdy); else n_pass++;
    drained = 0;
    while (exp_q.size() > 0 && drained < 20) begin
      n_total++; if (deq_data !== exp_q[0])
        $display("FAIL full_simul_data[%0d]: got %h want %h", drained, deq_data, exp_q[0]); else n_pass++;
      step(1'b0, '0, 1'b1);
      drained++;
    end
    n_total++; if (drained != DEPTH - 1 || o_empty !== 1'b1)
      $display("FAIL full_simul_count: got empty %b after %0d deq want 1 after 7", o_empty, drained); else n_pass++;
  endtask

  task automatic test_wrap_reset();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 5; i++) step(1'b1, W'($urandom_range(0, 255)), 1'b0);
      for (int i = 0; i < 5; i++) begin
        n_total++; if (exp_q.size() == 0 || deq_data !== exp_q[0])
          $display("FAIL wrap_data[%0d.%0d]: got %h want %h", r, i, deq_data, (exp_q.size() > 0) ? exp_q[0] : 8'h00); else n_pass++;
        step(1'b0, '0, 1'b1);
      end
    end
    for (int i = 0; i < 3; i++) step(1'b1, W'($urandom_range(0, 255)), 1'b0);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    n_total++; if (o_empty !== 1'b1 || o_full !== 1'b0 || deq_rdy !== 1'b0 || enq_rdy !== 1'b1)
      $display("FAIL async_reset: got empty %b full %b deq_rdy %b enq_rdy %b want 1 0 0 1", o_empty, o_full, deq_rdy, enq_rdy); else n_pass++;
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    step(1'b1, 8'h5A, 1'b0);
    n_total++; if (deq_data !== 8'h5A || o_empty !== 1'b0)
      $display("FAIL post_reset_enq: got %h empty %b want 5a 0", deq_data, o_empty); else n_pass++;
    step(1'b0, '0, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 55), W'($urandom_range(0, 255)), ($urandom_range(0, 99) < 45));
      n_total++; if (o_full !== (exp_q.size() == DEPTH) || o_empty !== (exp_q.size() == 0))
        $display("FAIL rand_flags[%0d]: got full %b empty %b want %b %b", i, o_full, o_empty, (exp_q.size() == DEPTH), (exp_q.size() == 0)); else n_pass++;
      if (exp_q.size() > 0) begin
        n_total++; if (deq_data !== exp_q[0])
          $display("FAIL rand_head[%0d]: got %h want %h", i, deq_data, exp_q[0]); else n_pass++;
      end
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_fill_overflow();
    test_drain_underflow();
    test_simul_one();
    test_full_simul();
    test_wrap_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
